// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller in front of a registered-read instruction ROM.
// A 2-entry output buffer hides the one-cycle ROM latency from the decode handshake.
module fetch_sequencer #(
  parameter int          ADDR_W   = 7,
  parameter int          DEPTH    = 35,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              Reset,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              instr_ready,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              halted,
  output logic [1:0]        dbg_state
);

  // instr/instr_pc are valid exactly while instr_valid is high; a transfer
  // happens on any cycle with instr_valid && instr_ready.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [31:0]       inflight_pc_q, inflight_pc_d;
  logic [31:0]       head_data_q, head_data_d, head_pc_q, head_pc_d;
  logic [31:0]       tail_data_q, tail_data_d, tail_pc_q, tail_pc_d;
  logic [1:0]        count_q, count_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;

  logic [31:0] redirect_target;
  logic [31:0] issue_pc;
  logic        issue;
  logic        pop;
  logic [1:0]  remaining;
  logic        fetch_in_range;
  logic        target_in_range;

  assign redirect_target = redirect_pc & ~32'h3;
  assign fetch_in_range  = fetch_pc_q[31:2] < DEPTH_W;
  assign target_in_range = redirect_target[31:2] < DEPTH_W;
  assign pop             = instr_valid && instr_ready;
  assign remaining       = count_q - {1'b0, pop};

  // Issue is only allowed when the entries left after this pop plus the read
  // in flight leave room, so the buffer can never overflow.
  always_comb begin
    issue    = 1'b0;
    issue_pc = fetch_pc_q;
    if (redirect_valid) begin
      issue_pc = redirect_target;
      issue    = target_in_range;
    end else if (state_q == ST_RUN) begin
      issue = fetch_in_range && (({1'b0, remaining} + {2'b00, inflight_q}) < 3'd2);
    end
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? issue_pc : inflight_pc_q;
    last_addr_d   = issue ? issue_pc[ADDR_W+1:2] : last_addr_q;
    head_data_d   = head_data_q;
    head_pc_d     = head_pc_q;
    tail_data_d   = tail_data_q;
    tail_pc_d     = tail_pc_q;
    count_d       = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_target + 32'd4;
      count_d    = 2'd0;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
      if (pop && (count_q == 2'd2)) begin
        head_data_d = tail_data_q;
        head_pc_d   = tail_pc_q;
      end
      if (inflight_q) begin
        if (remaining == 2'd0) begin
          head_data_d = mem_data;
          head_pc_d   = inflight_pc_q;
        end else begin
          tail_data_d = mem_data;
          tail_pc_d   = inflight_pc_q;
        end
      end
      count_d = remaining + {1'b0, inflight_q};
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      head_data_q   <= 32'h0000_0013;
      head_pc_q     <= 32'd0;
      tail_data_q   <= 32'd0;
      tail_pc_q     <= 32'd0;
      count_q       <= 2'd0;
      last_addr_q   <= RESET_PC[ADDR_W+1:2];
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_data_q   <= head_data_d;
      head_pc_q     <= head_pc_d;
      tail_data_q   <= tail_data_d;
      tail_pc_q     <= tail_pc_d;
      count_q       <= count_d;
      last_addr_q   <= last_addr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = target_in_range ? ST_RUN : ST_DRAIN;
    end else begin
      case (state_q)
        ST_RUN:   if (!fetch_in_range) state_d = ST_DRAIN;
        ST_DRAIN: if ((remaining == 2'd0) && !inflight_q) state_d = ST_HALT;
        ST_HALT:  state_d = ST_HALT;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    instr_valid = (count_q != 2'd0);
    instr       = head_data_q;
    instr_pc    = head_pc_q;
    halted      = (state_q == ST_HALT);
    dbg_state   = state_q;
    mem_addr    = issue ? issue_pc[ADDR_W+1:2] : last_addr_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: ROM word k holds 32'h1000_0000+k, expected
// values follow the cycle-by-cycle timing worked out by hand for each scenario.
module tb_fetch_sequencer;

  logic        clock;
  logic        Reset;
  logic [6:0]  mem_addr;
  logic [31:0] mem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        halted;
  logic [1:0]  dbg_state;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int check_cnt = 0;
  int cyc       = 0;

  fetch_sequencer #(.ADDR_W(7), .DEPTH(35), .RESET_PC(32'h0)) dut (
    .clock          (clock),
    .Reset          (Reset),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_ready    (instr_ready),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .halted         (halted),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] word(input int k);
    return 32'h1000_0000 + 32'(k);
  endfunction

  // registered-read ROM
  always @(posedge clock) begin
    if (mem_addr < 7'd35) mem_data <= 32'h1000_0000 + 32'(mem_addr);
    else                  mem_data <= 32'hDEAD_0000 + 32'(mem_addr);
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge clock);
    #1;
    Reset = 1'b0;
    cyc   = 0;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic v, input logic [31:0] ins,
                         input logic [31:0] pc);
    check({tag, "_valid"}, 32'(instr_valid), 32'(v));
    if (v) begin
      check({tag, "_instr"}, instr, ins);
      check({tag, "_pc"}, instr_pc, pc);
    end
  endtask

  initial begin
    Reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    instr_ready    = 1'b1;

    // Scenario 1: full stream to halt
    do_reset();
    #1;
    check("s1_rst_instr", instr, 32'h0000_0013);
    check("s1_rst_pc", instr_pc, 32'd0);
    check("s1_rst_state", 32'(dbg_state), 32'd0);
    check("s1_addr0", 32'(mem_addr), 32'd0);
    for (int c = 0; c <= 37; c++) begin
      if (c > 0) #1;
      if (c >= 2 && c <= 36) exp_out("s1", 1'b1, word(c - 2), 32'((c - 2) * 4));
      else                   exp_out("s1", 1'b0, 32'd0, 32'd0);
      check("s1_halted", 32'(halted), 32'(c >= 37));
      check("s1_addr_max", 32'(mem_addr <= 7'd34), 32'd1);
      step();
    end
    #1;
    check("s1_hold_instr", instr, word(34));
    check("s1_hold_pc", instr_pc, 32'h88);
    check("s1_halt_state", 32'(dbg_state), 32'd2);
    check("s1_halt_addr", 32'(mem_addr), 32'd34);

    // Scenario 4: redirect out of HALT to 0x0
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    #1;
    check("s4_halted_r", 32'(halted), 32'd1);
    check("s4_addr_r", 32'(mem_addr), 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    check("s4_halted_r1", 32'(halted), 32'd0);
    exp_out("s4_r1", 1'b0, 32'd0, 32'd0);
    step();
    for (int k = 0; k < 3; k++) begin
      #1;
      exp_out("s4_stream", 1'b1, word(k), 32'(k * 4));
      step();
    end

    // Scenario 2: backpressure in cycles 5..8
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      instr_ready = !(c >= 5 && c <= 8);
      #1;
      if (c < 2)       exp_out("s2", 1'b0, 32'd0, 32'd0);
      else if (c <= 4) exp_out("s2", 1'b1, word(c - 2), 32'((c - 2) * 4));
      else if (c <= 8) exp_out("s2", 1'b1, word(3), 32'h0C);
      else             exp_out("s2", 1'b1, word(c - 6), 32'((c - 6) * 4));
      if (c <= 4)      check("s2_addr", 32'(mem_addr), 32'(c));
      else if (c <= 8) check("s2_addr", 32'(mem_addr), 32'd4);
      else             check("s2_addr", 32'(mem_addr), 32'(c - 4));
      step();
    end

    // Scenario 3: redirect to 0x40 with buffer full and ready low
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      instr_ready    = (c < 5) || (c >= 11);
      redirect_valid = (c == 10);
      redirect_pc    = 32'h40;
      #1;
      if (c < 2)        exp_out("s3", 1'b0, 32'd0, 32'd0);
      else if (c <= 4)  exp_out("s3", 1'b1, word(c - 2), 32'((c - 2) * 4));
      else if (c <= 10) exp_out("s3", 1'b1, word(3), 32'h0C);
      else if (c == 11) exp_out("s3", 1'b0, 32'd0, 32'd0);
      else              exp_out("s3", 1'b1, word(16 + c - 12), 32'h40 + 32'((c - 12) * 4));
      if (c >= 10) check("s3_addr", 32'(mem_addr), 32'(c + 6));
      step();
    end
    redirect_valid = 1'b0;

    // Scenario 5: reset while two entries are buffered
    do_reset();
    instr_ready = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      #1;
      if (c < 2) exp_out("s5_pre", 1'b0, 32'd0, 32'd0);
      else       exp_out("s5_pre", 1'b1, word(0), 32'd0);
      if (c < 4) step();
    end
    do_reset();
    instr_ready = 1'b1;
    #1;
    check("s5_valid", 32'(instr_valid), 32'd0);
    check("s5_halted", 32'(halted), 32'd0);
    check("s5_instr", instr, 32'h0000_0013);
    check("s5_pc", instr_pc, 32'd0);
    step();
    for (int c = 1; c <= 5; c++) begin
      #1;
      if (c < 2) exp_out("s5", 1'b0, 32'd0, 32'd0);
      else       exp_out("s5", 1'b1, word(c - 2), 32'((c - 2) * 4));
      check("s5_addr", 32'(mem_addr), 32'(c));
      step();
    end

    // Scenario 6a: reset and redirect together, reset wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    do_reset();
    redirect_valid = 1'b0;
    for (int c = 0; c <= 2; c++) begin
      #1;
      check("s6a_addr", 32'(mem_addr), 32'(c));
      if (c < 2) exp_out("s6a", 1'b0, 32'd0, 32'd0);
      else       exp_out("s6a", 1'b1, word(0), 32'd0);
      step();
    end

    // Scenario 6b: redirect to unaligned 0x8A fetches word 34, drains, halts
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8A;
    #1;
    check("s6b_addr_r", 32'(mem_addr), 32'd34);
    step();
    redirect_valid = 1'b0;
    #1;
    exp_out("s6b_r1", 1'b0, 32'd0, 32'd0);
    check("s6b_addr_r1", 32'(mem_addr), 32'd34);
    check("s6b_halted_r1", 32'(halted), 32'd0);
    step();
    #1;
    exp_out("s6b_r2", 1'b1, word(34), 32'h88);
    check("s6b_halted_r2", 32'(halted), 32'd0);
    check("s6b_state_r2", 32'(dbg_state), 32'd1);
    step();
    #1;
    exp_out("s6b_r3", 1'b0, 32'd0, 32'd0);
    check("s6b_halted_r3", 32'(halted), 32'd1);
    check("s6b_state_r3", 32'(dbg_state), 32'd2);
    step();
    #1;
    check("s6b_halted_r4", 32'(halted), 32'd1);
    check("s6b_addr_r4", 32'(mem_addr), 32'd34);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program counter and fetch controller that drives the synchronous instruction ROM (registered read, data valid one cycle after the address is presented) and delivers instructions to decode over a valid/ready handshake.
- Hides the ROM read latency with a 2-entry output buffer.
- Discards in-flight reads on redirect.
- Stops fetching past the last ROM word and reports halt.

Parameters:
- ADDR_W, 7, ROM word-address width (mem_addr width)
- DEPTH, 35, number of valid ROM words; word index >= DEPTH is out of range
- RESET_PC, 32'h0000_0000, byte address fetched after reset

Ports:
- clock  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high reset
- mem_addr  out  ADDR_W  ROM word address issued this cycle = issue_pc[ADDR_W+1:2]
- mem_data  in  32  ROM read data for the address issued in the previous cycle
- redirect_valid  in  1  branch/jump redirect request, single-cycle pulse or held
- redirect_pc  in  32  redirect target byte address; bits [1:0] ignored (treated as 0)
- instr_ready  in  1  decode accepts instr this cycle
- instr_valid  out  1  instr/instr_pc hold a valid fetched instruction
- instr  out  32  instruction at head of output buffer
- instr_pc  out  32  byte address of instr
- halted  out  1  fetch stopped: PC out of range, buffer empty, nothing in flight

Behaviour:
- Reset (synchronous, overrides everything, including redirect):
  - fetch_pc=RESET_PC, buffer empty, inflight=0, state=RUN.
  - instr_valid=0, instr=32'h0000_0013, instr_pc=0, halted=0.
  - ROM data arriving the cycle after reset is dropped.
- Issue model:
  - The issued address is combinational, so mem_addr reflects this cycle's issue.
  - When not issuing, mem_addr holds the last issued value and the returning data is ignored.
- Issue condition in RUN: word index of fetch_pc < DEPTH AND (buffered entries remaining after this cycle's pop + inflight) < 2.
  - A pop is instr_valid && instr_ready.
  - On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
- Return path: if inflight is set, mem_data/inflight_pc are pushed into the buffer at the cycle's end.
  - The buffer is FIFO order and holds 2 entries max; overflow is impossible by construction.
  - instr/instr_pc always show the head entry.
- Latency: address issued in cycle n produces instr_valid=1 in cycle n+2.
  - With instr_ready held high, throughput is 1 instruction/cycle.
- Backpressure: while instr_valid && !instr_ready, instr and instr_pc are stable.
  - No instruction is lost or duplicated.
  - When instr_valid=0, instr/instr_pc hold their last value.
- Redirect (redirect_valid=1, not Reset), highest priority after Reset:
  - Buffer flushed, so instr_valid=0 next cycle, regardless of a handshake in the redirect cycle.
  - The in-flight read is discarded.
  - issue_pc = {redirect_pc[31:2],2'b00} is issued in the same cycle if in range; fetch_pc becomes target+4.
  - First target instruction is valid in cycle r+2.
  - State goes to RUN (or DRAIN if the target is out of range).
- States:
  - RUN: normal issue.
  - DRAIN: entered when fetch_pc word index >= DEPTH; no issue; wait for the buffer to empty and inflight=0.
  - HALT: entered from DRAIN when empty; halted=1 the same cycle the state is HALT; no issue.
  - Redirect in any state applies the redirect rules. halted drops to 0 in the cycle after a redirect out of HALT.
- Wrap-around: fetch_pc is not wrapped; reaching DEPTH halts.
- Reset mid-operation: all buffered/in-flight data is lost; restart follows the post-reset timing.

Test Plan:
1. ROM word k = 32'h1000_0000+k; Reset deasserted before cycle 0, instr_ready=1 -> instr_valid first high cycle 2 with instr 0x10000000, pc 0x0; one instr per cycle, pc +4; last is word 34, pc 0x88, in cycle 36; halted=1 from cycle 37; mem_addr never exceeds 34.
2. instr_ready=0 during cycles 5-8 -> instr/instr_pc frozen (word 3, pc 0x0C); no issue once 2 buffered + inflight cap is reached; after ready returns the sequence continues at word 4 with no gap, duplicate or loss.
3. Buffer full (ready=0), redirect_valid=1, redirect_pc=0x40 at cycle 10 -> cycle 11 instr_valid=0; cycle 12 instr=0x10000010, pc 0x40, then 0x44.
4. In HALT, redirect_pc=0x0 -> halted=0 next cycle; instr pc 0x0 valid two cycles after the redirect; normal stream resumes.
5. Reset asserted for 1 cycle while 2 entries are buffered and ready=0 -> next cycle instr_valid=0, halted=0, instr=0x00000013; restart identical to scenario 1 timing.
6. Reset and redirect_valid in the same cycle -> Reset wins, fetch restarts at RESET_PC. Separately, redirect_pc=0x8A -> fetch of pc 0x88 (word 34), then DRAIN, then HALT.
